cordic_phase_reducer: RTL and testbench
=======================================

Name: cordic_phase_reducer

Overview:
- Upstream/downstream sequencer for the cordic_cosine core.
- Accepts a full-circle unsigned phase on a valid/ready input.
- Folds the phase into the core's native range [-pi/2, pi/2), then drives the core's start/ready/done handshake and captures its result.
- Applies the quadrant sign correction and presents cos(phase) on a valid/ready output; lets upstream NCOs issue any angle.

Parameters:
- WIDTH, 32: phase, angle and value width; 2^WIDTH phase units = 2*pi.
- TIMEOUT_CYCLES, 1024: maximum cycles waiting on core_done before flagging an error.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  phase request valid
- in_ready  output  1  block can accept a phase
- in_phase  input  WIDTH  unsigned phase; 0x40000000 = pi/2
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_value  output  WIDTH  signed cosine, same fixed-point format as core_value
- core_start  output  1  start to cordic_cosine
- core_angle  output  WIDTH  signed core angle; 2^(WIDTH-1) = pi/2
- core_ready  input  1  core idle
- core_done  input  1  core result valid
- core_value  input  WIDTH  signed core result
- error  output  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset values (asynchronous): state IDLE; in_ready 0 during reset; out_valid 0; out_value 0; core_start 0; core_angle 0; error 0.
- Range reduction, with q = in_phase[WIDTH-1:WIDTH-2]:
  - q = 00 or 11: reduced = in_phase; negate = 0.
  - q = 01 or 10: reduced = in_phase + 2^(WIDTH-1), mod 2^WIDTH; negate = 1.
  - In both cases core_angle = reduced << 1 (drop MSB), interpreted as signed.
- Sign correction: if negate, out_value = -core_value; -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1. Otherwise out_value = core_value.
- FSM states: IDLE, ISSUE, RELEASE, HOLD.
  - IDLE: in_ready = core_ready. On in_valid && in_ready, register core_angle and negate, assert core_start next cycle, go to ISSUE.
  - ISSUE: core_start held high and core_angle held stable. On core_done == 1, capture the corrected value into out_value, drop core_start, go to RELEASE. If the wait counter reaches TIMEOUT_CYCLES, set error, drop core_start, go to IDLE with no output.
  - RELEASE: core_start 0. Wait for core_done == 0, then go to HOLD with out_valid = 1.
  - HOLD: out_valid and out_value held stable until out_ready == 1. On the handshake, out_valid drops next cycle and the FSM goes to IDLE.
- Latency: input accept to out_valid = core latency + 3 cycles.
- Throughput: one request in flight; in_ready is 0 outside IDLE.
- out_ready may be high before out_valid; the handshake completes in the first HOLD cycle.
- in_valid asserted while not in_ready: the request is ignored and must be held by the source.
- Reset mid-operation: all state clears at once and core_start falls; the core must also be reset.
- core_done already high on entry to ISSUE (stale): not valid. The sample is taken only after one ISSUE cycle with core_start asserted.

Decomposition:
- Package cordic_pkg holds:
  - localparam PHASE_HALF_PI = 32'h4000_0000.
  - localparam CORE_HALF_PI = 32'h8000_0000.
  - Enum reducer_state_t {IDLE, ISSUE, RELEASE, HOLD}.
  - Function sat_negate().
- No sub-module. The core is instantiated by the parent, which keeps this block testable with a behavioural core model.

Test Plan:
- Phase 0x00000000, model core returns 1000 -> core_angle 0x00000000; out_value 1000.
- Phase 0x80000000 (pi), core returns 1000 -> core_angle 0x00000000; out_value -1000.
- Phase 0xE0000000 (-pi/4) -> core_angle 0xC0000000, no negation. Phase 0x60000000 (3pi/4) -> core_angle 0xC0000000, negated.
- Quadrant-01 phase, core returns 0x80000000 -> out_value 0x7FFFFFFF (saturation).
- out_ready held low 5 cycles in HOLD -> out_valid and out_value stable, in_ready 0, a new in_valid is not accepted. Then raise out_ready -> out_valid drops next cycle and in_ready rises.
- Two fault cases:
  - Core never asserts done -> error 1 after TIMEOUT_CYCLES, core_start 0, back to IDLE.
  - Reset asserted mid-ISSUE -> core_start 0, out_valid 0 and error 0 immediately.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and helpers for the cordic_cosine phase reducer.
//   PHASE_HALF_PI   : pi/2 in full-circle phase units (32-bit phase)
//   CORE_HALF_PI    : pi/2 in core angle units (32-bit angle)
//   reducer_state_t : sequencer states
//   sat_negate()    : two's-complement negate of a w-bit value, saturating -2^(w-1)
package cordic_pkg;

   localparam logic [31:0] PHASE_HALF_PI = 32'h4000_0000;
   localparam logic [31:0] CORE_HALF_PI  = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RELEASE,
      HOLD
   } reducer_state_t;

   // v is a w-bit signed value sign-extended to 64 bits (w <= 64).
   function automatic logic signed [63:0] sat_negate(input logic signed [63:0] v,
                                                     input int unsigned       w);
      logic signed [63:0] min_v;
      logic signed [63:0] max_v;
      min_v = -(64'sd1 <<< (w - 1));
      max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (v == min_v) sat_negate = max_v;
      else            sat_negate = -v;
   endfunction

endpackage

// File: rtl/cordic_phase_reducer.sv
// Sequencer around the cordic_cosine core: folds a full-circle phase into the
// core's [-pi/2, pi/2) range, runs the core handshake, sign-corrects the result.
//   clk, reset             : clock, async active-high reset
//   in_valid/in_ready      : phase request handshake, in_phase unsigned full-circle
//   out_valid/out_ready    : result handshake, out_value signed cosine
//   core_start/core_angle  : request to the core (angle: 2^(WIDTH-1) = pi/2)
//   core_ready/core_done   : core idle / core result valid, core_value result
//   error                  : sticky core timeout flag
module cordic_phase_reducer
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_phase,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_value,
   output logic             core_start,
   output logic [WIDTH-1:0] core_angle,
   input  logic             core_ready,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_value,
   output logic             error
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   reducer_state_t   state_q, state_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic             negate_q, negate_nx;
   logic             idle_q, idle_nx;
   logic             start_nx, valid_nx, error_nx;
   logic [WIDTH-1:0] angle_nx, value_nx;

   logic             accept_c;
   logic             negate_c;
   logic [WIDTH-1:0] angle_c;
   logic [WIDTH-1:0] corrected_c;
   logic             done_ok_c;
   logic             timeout_c;

   // Quadrants 01/10 are folded by a half-turn and the result negated.
   assign negate_c = in_phase[WIDTH-1] ^ in_phase[WIDTH-2];
   // The half-turn fold only flips the MSB, which the doubling shift drops,
   // so the core angle is the phase shifted left in every quadrant.
   assign angle_c  = {in_phase[WIDTH-2:0], 1'b0};

   assign corrected_c = negate_q
                        ? WIDTH'(sat_negate(64'($signed(core_value)), WIDTH))
                        : core_value;

   assign in_ready  = idle_q & core_ready;
   assign accept_c  = in_valid & in_ready;
   // A done already high on ISSUE entry is stale; only trust it after one ISSUE cycle.
   assign done_ok_c = core_done && (cnt_q != '0);
   assign timeout_c = !done_ok_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_nx = ISSUE;
         ISSUE: begin
            if (done_ok_c)      state_nx = RELEASE;
            else if (timeout_c) state_nx = IDLE;
         end
         RELEASE: if (!core_done) state_nx = HOLD;
         HOLD:    if (out_ready)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output/datapath next values.
   always_comb begin
      start_nx  = core_start;
      angle_nx  = core_angle;
      negate_nx = negate_q;
      valid_nx  = out_valid;
      value_nx  = out_value;
      error_nx  = error;
      cnt_nx    = cnt_q;
      idle_nx   = (state_nx == IDLE);
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               angle_nx  = angle_c;
               negate_nx = negate_c;
               start_nx  = 1'b1;
               cnt_nx    = '0;
            end
         end
         ISSUE: begin
            cnt_nx = cnt_q + CNT_W'(1);
            if (done_ok_c) begin
               value_nx = corrected_c;
               start_nx = 1'b0;
            end else if (timeout_c) begin
               error_nx = 1'b1;
               start_nx = 1'b0;
            end
         end
         RELEASE: if (!core_done) valid_nx = 1'b1;
         HOLD:    if (out_ready)  valid_nx = 1'b0;
         default: ;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         core_start <= 1'b0;
         core_angle <= '0;
         negate_q   <= 1'b0;
         out_valid  <= 1'b0;
         out_value  <= '0;
         error      <= 1'b0;
         cnt_q      <= '0;
         idle_q     <= 1'b0;
      end else begin
         core_start <= start_nx;
         core_angle <= angle_nx;
         negate_q   <= negate_nx;
         out_valid  <= valid_nx;
         out_value  <= value_nx;
         error      <= error_nx;
         cnt_q      <= cnt_nx;
         idle_q     <= idle_nx;
      end
   end

endmodule

// File: tb/tb_cordic_phase_reducer.sv
// Directed bench for cordic_phase_reducer with a behavioural cordic_cosine model.
module tb_cordic_phase_reducer;

   localparam int unsigned W   = 32;
   localparam int unsigned TMO = 16;
   localparam int unsigned LAT = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_ready;
   logic [W-1:0] in_phase;
   logic         out_valid, out_ready;
   logic [W-1:0] out_value;
   logic         core_start;
   logic [W-1:0] core_angle;
   logic         core_ready, core_done;
   logic [W-1:0] core_value;
   logic         error;

   int n_tests = 0;
   int n_fail  = 0;

   // Core model controls.
   logic         hang = 1'b0;
   logic [W-1:0] model_val = '0;
   logic         busy;
   int           ccnt;

   cordic_phase_reducer #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_phase   (in_phase),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_value  (out_value),
      .core_start (core_start),
      .core_angle (core_angle),
      .core_ready (core_ready),
      .core_done  (core_done),
      .core_value (core_value),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Behavioural core: done rises LAT cycles after it latches start, falls once start drops.
   assign core_ready = !busy;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busy       <= 1'b0;
         core_done  <= 1'b0;
         ccnt       <= 0;
         core_value <= '0;
      end else if (!busy) begin
         if (core_start && !hang) begin
            busy <= 1'b1;
            ccnt <= 0;
         end
      end else if (!core_done) begin
         if (ccnt == int'(LAT) - 1) begin
            core_done  <= 1'b1;
            core_value <= model_val;
         end else begin
            ccnt <= ccnt + 1;
         end
      end else if (!core_start) begin
         core_done <= 1'b0;
         busy      <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a phase and hold it until accepted; returns on the negedge after acceptance.
   task automatic send(input logic [W-1:0] ph);
      int k;
      k        = 0;
      in_phase = ph;
      in_valid = 1'b1;
      while (!in_ready && k < 50) begin
         tick();
         k++;
      end
      check("accept_wait", W'(k < 50), W'(1));
      tick();
      in_valid = 1'b0;
   endtask

   // Full transaction; stall > 0 keeps out_ready low that many HOLD cycles.
   task automatic do_req(input string tag, input logic [W-1:0] ph, input logic [W-1:0] val,
                         input logic [W-1:0] exp_ang, input logic [W-1:0] exp_out,
                         input bit early, input int stall);
      int n;
      model_val = val;
      out_ready = early;
      send(ph);
      check({tag, "_angle"}, core_angle, exp_ang);
      check({tag, "_start"}, W'(core_start), W'(1));
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, W'(n), W'(LAT + 4));
      check({tag, "_value"}, out_value, exp_out);
      for (int i = 0; i < stall; i++) begin
         in_phase = 32'h1234_5678;
         in_valid = 1'b1;
         tick();
         check({tag, "_stall_valid"}, W'(out_valid), W'(1));
         check({tag, "_stall_value"}, out_value, exp_out);
         check({tag, "_stall_in_ready"}, W'(in_ready), W'(0));
         check({tag, "_stall_start"}, W'(core_start), W'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check({tag, "_valid_drop"}, W'(out_valid), W'(0));
      check({tag, "_in_ready_back"}, W'(in_ready), W'(1));
      out_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_phase  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready",   W'(in_ready),   W'(0));
      check("rst_out_valid",  W'(out_valid),  W'(0));
      check("rst_out_value",  out_value,      W'(0));
      check("rst_core_start", W'(core_start), W'(0));
      check("rst_core_angle", core_angle,     W'(0));
      check("rst_error",      W'(error),      W'(0));
      reset = 1'b0;
      @(negedge clk);

      do_req("ph0",      32'h0000_0000, 32'd1000,      32'h0000_0000, 32'd1000,      1'b0, 0);
      do_req("ph_pi",    32'h8000_0000, 32'd1000,      32'h0000_0000, 32'hFFFF_FC18, 1'b0, 0);
      do_req("ph_m_pi4", 32'hE000_0000, 32'h5A82_799A, 32'hC000_0000, 32'h5A82_799A, 1'b0, 0);
      do_req("ph_3pi4",  32'h6000_0000, 32'h5A82_799A, 32'hC000_0000, 32'hA57D_8666, 1'b1, 0);
      do_req("ph_sat",   32'h4000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
      do_req("ph_q0",    32'h2000_0000, 32'd12345,     32'h4000_0000, 32'd12345,     1'b0, 5);

      // Core never answers: error after TMO ISSUE cycles, back to IDLE.
      hang = 1'b1;
      send(32'h1000_0000);
      for (int n = 0; n < int'(TMO) - 1; n++) tick();
      check("tmo_error_early", W'(error),      W'(0));
      check("tmo_start_early", W'(core_start), W'(1));
      tick();
      check("tmo_error",     W'(error),      W'(1));
      check("tmo_start",     W'(core_start), W'(0));
      check("tmo_out_valid", W'(out_valid),  W'(0));
      check("tmo_in_ready",  W'(in_ready),   W'(1));
      tick();
      check("tmo_error_sticky", W'(error), W'(1));

      // Reset during ISSUE clears everything immediately.
      send(32'h0800_0000);
      tick();
      tick();
      check("mid_start_before", W'(core_start), W'(1));
      reset = 1'b1;
      #1;
      check("mid_rst_start",    W'(core_start), W'(0));
      check("mid_rst_valid",    W'(out_valid),  W'(0));
      check("mid_rst_error",    W'(error),      W'(0));
      check("mid_rst_in_ready", W'(in_ready),   W'(0));
      @(negedge clk);
      reset = 1'b0;
      hang  = 1'b0;
      @(negedge clk);

      do_req("post_rst", 32'hA000_0000, 32'd77, 32'h4000_0000, 32'hFFFF_FFB3, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
